// File: rtl/patch_fetcher.sv
// Purpose : fetch a PATCH_SIZE x PATCH_SIZE pixel patch centred on (req_cx, req_cy) from a
//           frame buffer, clamping coordinates at the frame edges, and stream it out in raster order.
// Latency : first out_valid 4 cycles after request acceptance, then one pixel per cycle.
//           Backpressure: out_ready low stalls the stream; reads are credit-limited so the FIFO never overflows.
//
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   req_valid/req_ready, req_cx/cy   - patch request handshake and centre coordinates
//   fb_read_enable, fb_read_x/y      - frame buffer read strobe (also pipeline advance) and address
//   fb_read_pixel                    - frame buffer data, valid two enabled edges after its address
//   out_valid/out_ready, out_pixel   - pixel stream handshake and data
//   out_px/out_py, out_clamped       - position inside the patch, edge-clamp flag
//   out_last, busy                   - final pixel of the patch, block not idle

// Small circular FIFO used as the output buffer. Pushes must never exceed capacity.
module patch_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   assign pop_dat = mem[rd_ptr];
endmodule

module patch_fetcher #(
   parameter int DATA_WIDTH   = 8,
   parameter int IMAGE_WIDTH  = 640,
   parameter int IMAGE_HEIGHT = 480,
   parameter int PATCH_SIZE   = 31,
   parameter int FIFO_DEPTH   = 4,
   localparam int XW = $clog2(IMAGE_WIDTH),
   localparam int YW = $clog2(IMAGE_HEIGHT),
   localparam int PW = $clog2(PATCH_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [XW-1:0]         req_cx,
   input  logic [YW-1:0]         req_cy,
   output logic                  fb_read_enable,
   output logic [XW-1:0]         fb_read_x,
   output logic [YW-1:0]         fb_read_y,
   input  logic [DATA_WIDTH-1:0] fb_read_pixel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_pixel,
   output logic [PW-1:0]         out_px,
   output logic [PW-1:0]         out_py,
   output logic                  out_clamped,
   output logic                  out_last,
   output logic                  busy
);
   localparam int R  = (PATCH_SIZE - 1) / 2;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = DATA_WIDTH + 2 * PW + 1;
   localparam logic [PW-1:0]    P_LAST = PW'(PATCH_SIZE - 1);
   localparam logic signed [XW:0] R_X   = (XW + 1)'(R);
   localparam logic signed [YW:0] R_Y   = (YW + 1)'(R);
   localparam logic signed [XW:0] X_MAX = (XW + 1)'(IMAGE_WIDTH - 1);
   localparam logic signed [YW:0] Y_MAX = (YW + 1)'(IMAGE_HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
   state_t state;

   logic [XW-1:0] cx_q, last_x, rd_x;
   logic [YW-1:0] cy_q, last_y, rd_y;
   logic [PW-1:0] ipx, ipy;
   logic signed [XW:0] sx;
   logic signed [YW:0] sy;
   logic          clamp_x, clamp_y;
   logic          t1, t2;
   logic [PW-1:0] t1_px, t1_py, t2_px, t2_py;
   logic          t1_clamp, t2_clamp;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   inflight;
   logic          issue, accept, pop;
   logic [EW-1:0] head;

   // Signed read coordinate, then clamp into the frame.
   always_comb begin
      sx = $signed({1'b0, cx_q}) - R_X + $signed((XW + 1)'(ipx));
      sy = $signed({1'b0, cy_q}) - R_Y + $signed((YW + 1)'(ipy));
      rd_x    = sx[XW-1:0];
      clamp_x = 1'b0;
      if (sx[XW]) begin
         rd_x    = '0;
         clamp_x = 1'b1;
      end else if (sx > X_MAX) begin
         rd_x    = XW'(IMAGE_WIDTH - 1);
         clamp_x = 1'b1;
      end
      rd_y    = sy[YW-1:0];
      clamp_y = 1'b0;
      if (sy[YW]) begin
         rd_y    = '0;
         clamp_y = 1'b1;
      end else if (sy > Y_MAX) begin
         rd_y    = YW'(IMAGE_HEIGHT - 1);
         clamp_y = 1'b1;
      end
   end

   // Every read in flight (t1, t2) already owns a FIFO slot, so a push can never find it full.
   assign inflight       = {1'b0, fifo_count} + (CW + 1)'(t1) + (CW + 1)'(t2);
   assign issue          = (state == FETCH) && (inflight < (CW + 1)'(FIFO_DEPTH));
   // Keep strobing while a read sits in t1 so its data is clocked out of the frame buffer.
   assign fb_read_enable = issue || t1;
   assign fb_read_x      = issue ? rd_x : last_x;
   assign fb_read_y      = issue ? rd_y : last_y;

   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign busy      = (state != IDLE);

   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid && out_ready;
   assign {out_pixel, out_px, out_py, out_clamped} = head;
   assign out_last  = out_valid && (out_px == P_LAST) && (out_py == P_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         t1    <= 1'b0;
         t2    <= 1'b0;
      end else begin
         case (state)
            IDLE:    if (accept) state <= FETCH;
            FETCH:   if (issue && ipx == P_LAST && ipy == P_LAST) state <= DRAIN;
            DRAIN:   if (pop && out_last) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (fb_read_enable) begin
            t1 <= issue;
            t2 <= t1;
         end else begin
            t2 <= 1'b0;
         end
      end
   end

   // Datapath registers: contents are don't-care while idle, so no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         cx_q <= req_cx;
         cy_q <= req_cy;
         ipx  <= '0;
         ipy  <= '0;
      end
      if (issue) begin
         last_x <= rd_x;
         last_y <= rd_y;
         if (ipx == P_LAST) begin
            ipx <= '0;
            ipy <= ipy + 1'b1;
         end else begin
            ipx <= ipx + 1'b1;
         end
      end
      if (fb_read_enable) begin
         t1_px    <= ipx;
         t1_py    <= ipy;
         t1_clamp <= clamp_x || clamp_y;
         t2_px    <= t1_px;
         t2_py    <= t1_py;
         t2_clamp <= t1_clamp;
      end
   end

   patch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (t2),
      .push_dat ({fb_read_pixel, t2_px, t2_py, t2_clamp}),
      .pop      (pop),
      .pop_dat  (head),
      .count    (fifo_count)
   );
endmodule

// File: tb/tb_patch_fetcher.sv
module tb_patch_fetcher;
   localparam int P = 31;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [9:0] req_cx = '0;
   logic [8:0] req_cy = '0;
   logic       fb_read_enable;
   logic [9:0] fb_read_x;
   logic [8:0] fb_read_y;
   logic [7:0] fb_read_pixel = '0;
   logic [7:0] fb_stage = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_pixel;
   logic [4:0] out_px, out_py;
   logic       out_clamped, out_last, busy;

   patch_fetcher dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_cx(req_cx), .req_cy(req_cy),
      .fb_read_enable(fb_read_enable), .fb_read_x(fb_read_x), .fb_read_y(fb_read_y),
      .fb_read_pixel(fb_read_pixel),
      .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
      .out_px(out_px), .out_py(out_py), .out_clamped(out_clamped), .out_last(out_last),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] pix(input int x, input int y);
      return 8'((x + 17 * y) & 255);
   endfunction

   // Two-stage frame buffer: address at edge N, data after edge N+1, both stages gated by enable.
   always @(posedge clk) begin
      if (fb_read_enable) begin
         fb_stage      <= pix(int'(fb_read_x), int'(fb_read_y));
         fb_read_pixel <= fb_stage;
      end
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                    name, act, act, exp, exp, cyc);
   endtask

   // Expected beat word: {pixel, px, py, clamped, last}
   logic [19:0] sb[$];

   function automatic logic [19:0] model(input int cx, input int cy, input int px, input int py);
      int sx, sy, x, y;
      logic c, l;
      sx = cx - 15 + px;
      sy = cy - 15 + py;
      x = (sx < 0) ? 0 : ((sx > 639) ? 639 : sx);
      y = (sy < 0) ? 0 : ((sy > 479) ? 479 : sy);
      c = (x != sx) || (y != sy);
      l = (px == P - 1) && (py == P - 1);
      return {pix(x, y), 5'(px), 5'(py), c, l};
   endfunction

   task automatic push_patch(input int cx, input int cy);
      for (int py = 0; py < P; py++)
         for (int px = 0; px < P; px++)
            sb.push_back(model(cx, cy, px, py));
   endtask

   typedef struct {int patch; int px; int py; int pix; int clamp;} spot_t;
   spot_t spots[$];
   int spot_hits = 0;

   task automatic add_spot(input int patch, input int px, input int py, input int pv, input int c);
      spot_t s;
      s.patch = patch; s.px = px; s.py = py; s.pix = pv; s.clamp = c;
      spots.push_back(s);
   endtask

   // Monitor state
   int  ready_mode = 0;
   int  chk_consec = 0;
   int  pbeat = 0;
   int  patch_no = 0;
   int  first_cyc = 0;
   int  n_acc = 0;
   int  inflight;
   logic        prev_stall = 1'b0;
   logic [19:0] prev_word = '0;
   logic [19:0] cur_word;
   logic [19:0] exp_word;

   always @(negedge clk) begin
      cur_word = {out_pixel, out_px, out_py, out_clamped, out_last};
      if (rst) begin
         prev_stall = 1'b0;
         pbeat = 0;
      end else begin
         if (req_valid && req_ready) n_acc++;
         inflight = int'(dut.fifo_count) + int'(dut.t1) + int'(dut.t2);
         check("credit_bound", int'(inflight <= 4), 1);
         if (inflight >= 4) check("no_issue_when_full", int'(dut.issue), 0);
         if (fb_read_enable)
            check("read_in_frame", int'(fb_read_x < 640 && fb_read_y < 480), 1);
         if (prev_stall)
            check("stall_hold", int'({out_valid, cur_word}), int'({1'b1, prev_word}));
         if (out_valid && out_ready) begin
            check("beat_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               exp_word = sb.pop_front();
               check("beat", int'(cur_word), int'(exp_word));
            end
            foreach (spots[i]) begin
               if (spots[i].patch == patch_no && spots[i].px == int'(out_px) &&
                   spots[i].py == int'(out_py)) begin
                  check("spot_pix", int'(out_pixel), spots[i].pix);
                  check("spot_clamp", int'(out_clamped), spots[i].clamp);
                  spot_hits++;
               end
            end
            if (pbeat == 0) first_cyc = cyc;
            pbeat++;
            if (out_last) begin
               if (chk_consec != 0) check("consecutive_beats", cyc - first_cyc, P * P - 1);
               patch_no++;
               pbeat = 0;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_word  = cur_word;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   task automatic request(input int cx, input int cy);
      bit ok;
      ok = 0;
      push_patch(cx, cy);
      @(posedge clk);
      #1;
      req_cx = 10'(cx);
      req_cy = 9'(cy);
      req_valid = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1; break; end
      end
      check("request_accepted", int'(ok), 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         if (!busy && !out_valid && sb.size() == 0) begin ok = 1; break; end
      end
      check("patch_complete", int'(ok), 1);
   endtask

   task automatic wait_beats(input int n);
      bit ok;
      ok = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (pbeat >= n) begin ok = 1; break; end
      end
      check("beats_reached", int'(ok), 1);
   endtask

   initial begin
      int lat, lows, acc0;
      bit ok;
      // Hand-computed spot values, pix(x,y) = (x + 17*y) mod 256
      add_spot(0, 0, 0, 250, 0);     // (85,85)
      add_spot(0, 15, 15, 8, 0);     // (100,100)
      add_spot(0, 30, 30, 22, 0);    // (115,115)
      add_spot(1, 0, 0, 0, 1);       // clamped to (0,0)
      add_spot(1, 15, 15, 0, 0);     // true (0,0)
      add_spot(1, 30, 30, 14, 0);    // (15,15)
      add_spot(1, 14, 20, 85, 1);    // x clamped, y=5
      add_spot(1, 20, 14, 5, 1);     // x=5, y clamped
      add_spot(2, 0, 0, 64, 0);      // (624,464)
      add_spot(2, 15, 15, 78, 0);    // true (639,479)
      add_spot(2, 30, 30, 78, 1);    // clamped to (639,479)
      add_spot(2, 16, 10, 249, 1);   // x clamped to 639, y=474

      @(negedge clk);
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_fb_en", int'(fb_read_enable), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_last", int'(out_last), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", int'(req_ready), 1);

      // Centre patch, latency and streaming
      chk_consec = 1;
      request(100, 100);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (out_valid) begin lat = k; break; end
      end
      check("first_valid_latency", lat, 4);
      wait_idle();

      // Corners
      request(0, 0);
      wait_idle();
      request(639, 479);
      wait_idle();

      // Random backpressure with a 20-cycle stall
      chk_consec = 0;
      ready_mode = 1;
      request(5, 470);
      wait_beats(300);
      ready_mode = 2;
      repeat (20) @(posedge clk);
      ready_mode = 1;
      wait_idle();
      ready_mode = 0;

      // Reset mid-patch
      request(200, 50);
      wait_beats(100);
      @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      @(negedge clk);
      check("abort_req_ready", int'(req_ready), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_fb_en", int'(fb_read_enable), 0);
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_out_last", int'(out_last), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", int'(req_ready), 1);
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_out_valid", int'(out_valid), 0);
      chk_consec = 1;
      request(320, 240);
      wait_idle();

      // Two back-to-back requests with req_valid held high
      acc0 = n_acc;
      push_patch(10, 20);
      @(posedge clk);
      #1;
      req_cx = 10'd10;
      req_cy = 9'd20;
      req_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1; break; end
      end
      check("b2b_first_accept", int'(ok), 1);
      @(posedge clk);
      #1;
      push_patch(630, 5);
      req_cx = 10'd630;
      req_cy = 9'd5;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1; break; end
      end
      check("b2b_idle_seen", int'(ok), 1);
      lows = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy) break;
         lows++;
      end
      check("b2b_idle_gap", lows, 1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_idle();
      check("b2b_accept_count", n_acc - acc0, 2);

      check("scoreboard_empty", sb.size(), 0);
      check("spot_hits", spot_hits, spots.size());
      check("patches_done", patch_no, 7);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/patch_fetcher.md
PATCH_FETCHER -- requirements
Module: patch_fetcher

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 8: pixel width.
REQ-002 SHALL take parameter IMAGE_WIDTH, default 640: frame columns; XW = $clog2(IMAGE_WIDTH).
REQ-003 SHALL take parameter IMAGE_HEIGHT, default 480: frame rows; YW = $clog2(IMAGE_HEIGHT).
REQ-004 SHALL take parameter PATCH_SIZE, default 31: patch side P, odd only; R = (P-1)/2; PW = $clog2(P).
REQ-005 SHALL take parameter FIFO_DEPTH, default 4: output buffer entries, minimum 4.
REQ-006 SHALL have one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 req_valid / req_ready  in / out  1 / 1  patch request handshake.
REQ-010 req_cx / req_cy  in  XW / YW  patch centre coordinates.
REQ-011 fb_read_enable  out  1  frame buffer read strobe and pipeline advance.
REQ-012 fb_read_x / fb_read_y  out  XW / YW  frame buffer read coordinates.
REQ-013 fb_read_pixel  in  DATA_WIDTH  frame buffer read data.
REQ-014 out_valid / out_ready  out / in  1 / 1  pixel stream handshake.
REQ-015 out_pixel  out  DATA_WIDTH  patch pixel.
REQ-016 out_px / out_py  out  PW / PW  pixel position in the patch, 0..P-1.
REQ-017 out_clamped  out  1  pixel coordinate was clamped at the frame edge.
REQ-018 out_last  out  1  final pixel of the patch.
REQ-019 busy  out  1  high whenever the state is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, FETCH and DRAIN. IDLE moves to FETCH on req_valid&&req_ready. FETCH moves to DRAIN after P*P reads are issued. DRAIN moves to IDLE on the out_last handshake.
REQ-021 req_ready SHALL be high only in IDLE; req_cx and req_cy SHALL be latched on acceptance.
REQ-022 Reads SHALL be issued in raster order, px fastest. Read coordinates: x = clamp(cx-R+px, 0, IMAGE_WIDTH-1) and y = clamp(cy-R+py, 0, IMAGE_HEIGHT-1), computed signed at XW+1 / YW+1 bits.
REQ-023 Frame buffer protocol: an address presented with fb_read_enable=1 at edge N returns its data on fb_read_pixel after edge N+1, provided fb_read_enable=1 at edge N+1.
REQ-024 Tag pipeline t1/t2: at each edge with fb_read_enable=1, t1<=issue and t2<=t1. At an edge with fb_read_enable=0, t1 holds and t2<=0.
REQ-025 fb_read_enable SHALL equal issue||t1; when not issuing, fb_read_x/fb_read_y SHALL hold the last address.
REQ-026 A read SHALL be issued only in FETCH and only when fifo_count+t1+t2 < FIFO_DEPTH.
REQ-027 When t2=1, fb_read_pixel and its px, py and clamped tags SHALL be pushed into the FIFO at that edge.
REQ-028 The FIFO SHALL never overflow and SHALL never drop a pixel under any out_ready pattern.
REQ-029 out_valid SHALL equal FIFO non-empty; out_* SHALL show the FIFO head and stay stable while out_valid&&!out_ready.
REQ-030 With out_ready held at 1: first out_valid SHALL appear 4 cycles after the acceptance cycle, then all P*P pixels on consecutive cycles.
REQ-031 out_last SHALL be 1 only with px=P-1 and py=P-1.
REQ-032 A new request SHALL NOT be accepted in the same cycle as the out_last handshake; the block returns to IDLE on the following cycle.

Reset
REQ-033 While rst=1: state=IDLE, req_ready=0, busy=0, fb_read_enable=0, out_valid=0, out_last=0, t1=t2=0, FIFO empty.
REQ-034 Reset asserted mid-operation SHALL abort the patch with no residual output after rst deasserts; pixel data and coordinate registers need no reset.
REQ-035 req_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-036 Centre (100,100), P=31, out_ready=1 -> 961 beats; first (85,85) px=0 py=0; last (115,115) with out_last=1; beats consecutive; out_clamped always 0.
REQ-037 Corner (0,0) -> reads clamp to x,y>=0; out_clamped=1 iff px<15 or py<15; beat px=15,py=15 reads (0,0) with out_clamped=0.
REQ-038 Corner (639,479) -> x clamps to 639 for px>15, y clamps to 479 for py>15; no read exceeds the frame bounds.
REQ-039 out_ready toggled randomly plus a 20-cycle stall mid-patch -> all 961 pixels correct and in order; fifo_count+t1+t2 <= 4 every cycle; no issue while the credit is exhausted.
REQ-040 rst pulsed in FETCH after 100 beats -> outputs idle next cycle; a new request after rst yields a complete, correct 961-beat patch.
REQ-041 req_valid held high for two requests -> second accepted only after IDLE is re-entered; busy low exactly one cycle between patches.
